pwm_audio_dac: RTL

- Multi-channel PWM audio DAC, the parametrised successor to the fixed 2×9-bit stereo PWM pair driven by the APU mixer outputs.
- Accepts frames of two's-complement samples through a valid/ready handshake and double-buffers them.
- Latches a new duty set only at PWM period boundaries, so no glitched periods occur.
- Adds per-channel mute, power-of-two gain with saturation, and an optional first-order noise-shaping mode that preserves resolution below PWM_WIDTH.

---
 rtl/pwm_audio_dac.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pwm_audio_dac.sv
// Multi-channel PWM audio DAC. Frames are double-buffered and applied only at period
// boundaries, with per-channel mute, power-of-two gain and optional noise shaping.

module pwm_audio_dac_lane #(
  parameter int IN_WIDTH  = 16,
  parameter int PWM_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 latch,
  input  logic [PWM_WIDTH-1:0] cnt,
  input  logic [IN_WIDTH-1:0]  sample,
  input  logic                 mute,
  input  logic [1:0]           gain_shift,
  input  logic                 shape_en,
  output logic                 pwm
);
  localparam int EW = IN_WIDTH - PWM_WIDTH;
  localparam int XW = IN_WIDTH + 3;
  localparam logic signed [XW-1:0] SMAX = {{4{1'b0}}, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{4{1'b1}}, {(IN_WIDTH-1){1'b0}}};
  localparam logic [PWM_WIDTH-1:0] MID  = {1'b1, {(PWM_WIDTH-1){1'b0}}};

  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic [EW-1:0]        err_q, err_d;
  logic                 pwm_q, pwm_d;

  logic signed [XW-1:0] ext, shifted;
  logic [IN_WIDTH-1:0]  sat, u;
  logic [IN_WIDTH:0]    acc;

  // Three guard bits cover the largest shift, so the saturation compare sees the true value.
  always_comb begin
    ext     = {{3{sample[IN_WIDTH-1]}}, sample};
    shifted = ext <<< gain_shift;
    if (shifted > SMAX)      sat = SMAX[IN_WIDTH-1:0];
    else if (shifted < SMIN) sat = SMIN[IN_WIDTH-1:0];
    else                     sat = shifted[IN_WIDTH-1:0];
    u   = {~sat[IN_WIDTH-1], sat[IN_WIDTH-2:0]};
    acc = {1'b0, u} + {{(PWM_WIDTH+1){1'b0}}, err_q};
  end

  always_comb begin
    duty_d = duty_q;
    err_d  = err_q;
    pwm_d  = pwm_q;
    if (latch) begin
      if (mute) begin
        duty_d = MID;
      end else if (shape_en) begin
        if (acc[IN_WIDTH]) begin
          duty_d = {PWM_WIDTH{1'b1}};
          err_d  = '0;
        end else begin
          duty_d = acc[IN_WIDTH-1 -: PWM_WIDTH];
          err_d  = acc[EW-1:0];
        end
      end else begin
        duty_d = u[IN_WIDTH-1 -: PWM_WIDTH];
        err_d  = '0;
      end
    end
    if (ce) pwm_d = (cnt < duty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= MID;
      err_q  <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      err_q  <= err_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;
endmodule

module pwm_audio_dac #(
  parameter int CHANNELS  = 2,
  parameter int IN_WIDTH  = 16,
  parameter int PWM_WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic [CHANNELS*IN_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [CHANNELS-1:0]          mute,
  input  logic [1:0]                   gain_shift,
  input  logic                         shape_en,
  output logic [CHANNELS-1:0]          pwm,
  output logic                         period_start,
  output logic                         underrun
);
  logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 period_start_q, period_start_d;
  logic                 underrun_q, underrun_d;
  logic [CHANNELS-1:0][IN_WIDTH-1:0] hold_q, hold_d, prev_q, prev_d, lane_sample;
  logic                 latch;

  assign latch = ce & (&cnt_q);

  // Holding only empties at a latch, and only accepts while empty, so the two never collide.
  always_comb begin
    cnt_d          = cnt_q;
    full_d         = full_q;
    hold_d         = hold_q;
    prev_d         = prev_q;
    period_start_d = latch;
    underrun_d     = latch & ~full_q;
    if (ce) cnt_d = cnt_q + 1'b1;
    if (latch && full_q) begin
      full_d = 1'b0;
      prev_d = hold_q;
    end else if (sample_valid && !full_q) begin
      hold_d = sample_in;
      full_d = 1'b1;
    end
  end

  // On underrun the previous frame is reconverted so shaping error keeps advancing.
  always_comb lane_sample = full_q ? hold_q : prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      full_q         <= 1'b0;
      hold_q         <= '0;
      prev_q         <= '0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      full_q         <= full_d;
      hold_q         <= hold_d;
      prev_q         <= prev_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pwm_audio_dac_lane #(
      .IN_WIDTH  (IN_WIDTH),
      .PWM_WIDTH (PWM_WIDTH)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .latch      (latch),
      .cnt        (cnt_q),
      .sample     (lane_sample[c]),
      .mute       (mute[c]),
      .gain_shift (gain_shift),
      .shape_en   (shape_en),
      .pwm        (pwm[c])
    );
  end

  assign sample_ready = ~full_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;
endmodule
